// File: rtl/div_pkg.sv
// Shared state encoding and constants for the sequential 24/12 signed divider.
package div_pkg;
    localparam int DVD_W = 24;
    localparam int DVS_W = 12;
    localparam logic [DVD_W-1:0] DIV0_QUOT = 24'hFFFFFF;
    localparam int CNT_W = $clog2(DVD_W);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
endpackage

// File: rtl/seq_div24x12_twos_neg.sv
// Conditional two's complement negation: out = neg_en ? -in : in.
module twos_neg #(
    parameter int W = 8
) (
    input  logic [W-1:0] in,
    input  logic         neg_en,
    output logic [W-1:0] out
);
    assign out = neg_en ? (~in + W'(1)) : in;
endmodule

// File: rtl/seq_div24x12.sv
// Restoring signed divider, one quotient bit per clock, with ready/valid on both sides.
// Operands are reduced to magnitudes on entry and the signs are reapplied in FIXUP.
module seq_div24x12 #(
    parameter int DVD_W = div_pkg::DVD_W,
    parameter int DVS_W = div_pkg::DVS_W
) (
    input  logic             Clk,
    input  logic             Rst_N,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [DVD_W-1:0] Dividend,
    input  logic [DVS_W-1:0] Divisor,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [DVD_W-1:0] Quotient,
    output logic [DVS_W-1:0] Remainder,
    output logic             Div_By_Zero,
    output logic             Overflow
);
    import div_pkg::*;

    localparam int PR_W = DVD_W + 1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [PR_W-1:0]  part_rem;
    logic [DVD_W-1:0] quot_mag;
    logic [DVS_W-1:0] dvs_mag_r;
    logic [DVS_W-1:0] dvd_low;
    logic             q_sign;
    logic             r_sign;
    logic             by_zero;
    logic             ovf_case;

    logic [DVD_W-1:0] dvd_mag;
    logic [DVD_W-1:0] quot_fixed;
    logic [DVS_W-1:0] dvs_mag;
    logic [DVS_W-1:0] rem_fixed;
    logic [PR_W-1:0]  shifted;
    logic [PR_W-1:0]  trial;
    logic             trial_ok;
    logic             accept;
    logic             dvs_zero;
    logic             ovf_operands;

    twos_neg #(.W(DVD_W)) u_dvd_mag  (.in(Dividend),             .neg_en(Dividend[DVD_W-1]), .out(dvd_mag));
    twos_neg #(.W(DVS_W)) u_dvs_mag  (.in(Divisor),              .neg_en(Divisor[DVS_W-1]),  .out(dvs_mag));
    twos_neg #(.W(DVD_W)) u_quot_fix (.in(quot_mag),             .neg_en(q_sign),            .out(quot_fixed));
    twos_neg #(.W(DVS_W)) u_rem_fix  (.in(part_rem[DVS_W-1:0]),  .neg_en(r_sign),            .out(rem_fixed));

    assign In_Ready     = (state == IDLE);
    assign Out_Valid    = (state == DONE);
    assign accept       = In_Valid && In_Ready;
    assign dvs_zero     = (Divisor == '0);
    assign ovf_operands = (Dividend == {1'b1, {(DVD_W-1){1'b0}}}) && (Divisor == '1);

    // quot_mag doubles as the dividend shift register: its MSB feeds the partial
    // remainder while the new quotient bit enters at its LSB.
    assign shifted  = (part_rem << 1) | PR_W'(quot_mag[DVD_W-1]);
    assign trial    = shifted - PR_W'(dvs_mag_r);
    assign trial_ok = ~trial[PR_W-1];

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (In_Valid) state_next = dvs_zero ? FIXUP : CALC;
            CALC:    if (count == '0) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE:    if (Out_Ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            count       <= '0;
            part_rem    <= '0;
            quot_mag    <= '0;
            dvs_mag_r   <= '0;
            dvd_low     <= '0;
            q_sign      <= 1'b0;
            r_sign      <= 1'b0;
            by_zero     <= 1'b0;
            ovf_case    <= 1'b0;
            Quotient    <= '0;
            Remainder   <= '0;
            Div_By_Zero <= 1'b0;
            Overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        quot_mag  <= dvd_mag;
                        dvs_mag_r <= dvs_mag;
                        dvd_low   <= Dividend[DVS_W-1:0];
                        q_sign    <= Dividend[DVD_W-1] ^ Divisor[DVS_W-1];
                        r_sign    <= Dividend[DVD_W-1];
                        by_zero   <= dvs_zero;
                        ovf_case  <= ovf_operands;
                        part_rem  <= '0;
                        count     <= CNT_W'(DVD_W - 1);
                    end
                end
                CALC: begin
                    part_rem <= trial_ok ? trial : shifted;
                    quot_mag <= {quot_mag[DVD_W-2:0], trial_ok};
                    if (count != '0) count <= count - 1'b1;
                end
                FIXUP: begin
                    Quotient    <= by_zero ? DIV0_QUOT : quot_fixed;
                    Remainder   <= by_zero ? dvd_low : rem_fixed;
                    Div_By_Zero <= by_zero;
                    Overflow    <= ovf_case && !by_zero;
                end
                DONE: begin
                    // Result registers keep their value after hand-off; only the flags drop.
                    if (Out_Ready) begin
                        Div_By_Zero <= 1'b0;
                        Overflow    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_div24x12.sv
// Self-checking bench for seq_div24x12: integer-arithmetic reference model,
// per-cycle compare of handshake, latency and result against that model.
module tb_seq_div24x12;
    logic        Clk = 1'b0;
    logic        Rst_N;
    logic        In_Valid;
    logic        In_Ready;
    logic [23:0] Dividend;
    logic [11:0] Divisor;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [23:0] Quotient;
    logic [11:0] Remainder;
    logic        Div_By_Zero;
    logic        Overflow;

    typedef struct packed {
        logic [23:0] quot;
        logic [11:0] rem;
        logic        dz;
        logic        ov;
        logic [7:0]  lat;
    } exp_t;

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   acc_cyc    = 0;
    bit   pending    = 1'b0;
    bit   started    = 1'b0;
    exp_t cur;

    seq_div24x12 dut (
        .Clk(Clk), .Rst_N(Rst_N),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Dividend(Dividend), .Divisor(Divisor),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Quotient(Quotient), .Remainder(Remainder),
        .Div_By_Zero(Div_By_Zero), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    // Reference result from plain signed integer division (truncates toward zero,
    // remainder takes the dividend's sign), plus the special cases.
    function automatic exp_t model(input logic [23:0] dvd, input logic [11:0] dvs);
        exp_t e;
        int   a;
        int   b;
        a = int'($signed(dvd));
        b = int'($signed(dvs));
        e = '0;
        if (b == 0) begin
            e.quot = 24'hFFFFFF;
            e.rem  = dvd[11:0];
            e.dz   = 1'b1;
            e.lat  = 8'd2;
        end else if (a == -8388608 && b == -1) begin
            e.quot = 24'h800000;
            e.rem  = 12'h000;
            e.ov   = 1'b1;
            e.lat  = 8'd26;
        end else begin
            e.quot = 24'(a / b);
            e.rem  = 12'(a % b);
            e.lat  = 8'd26;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Transaction tracker: the acceptance cycle counts as cycle 0 of the latency.
    always @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            pending <= 1'b0;
        end else begin
            if (pending) begin
                if ((cyc - acc_cyc) >= int'(cur.lat) && Out_Ready) pending <= 1'b0;
            end else if (In_Valid) begin
                cur     <= model(Dividend, Divisor);
                acc_cyc <= cyc;
                pending <= 1'b1;
            end
            cyc <= cyc + 1;
        end
    end

    always @(negedge Clk) begin
        logic exp_v;
        if (Rst_N && started) begin
            exp_v = pending && ((cyc - acc_cyc) >= int'(cur.lat));
            checkOutput("out_valid", 32'(Out_Valid), 32'(exp_v));
            checkOutput("in_ready", 32'(In_Ready), 32'(!pending));
            if (exp_v) begin
                checkOutput("quotient", 32'(Quotient), 32'(cur.quot));
                checkOutput("remainder", 32'(Remainder), 32'(cur.rem));
                checkOutput("div_by_zero", 32'(Div_By_Zero), 32'(cur.dz));
                checkOutput("overflow", 32'(Overflow), 32'(cur.ov));
            end else if (!pending) begin
                checkOutput("idle_div_by_zero", 32'(Div_By_Zero), 32'd0);
                checkOutput("idle_overflow", 32'(Overflow), 32'd0);
            end
        end
    end

    task automatic applyStimulus(input logic [23:0] dvd, input logic [11:0] dvs, input int hold, input bit junk);
        int waited;
        @(negedge Clk);
        Dividend  = dvd;
        Divisor   = dvs;
        In_Valid  = 1'b1;
        Out_Ready = 1'b0;
        @(negedge Clk);
        In_Valid = junk;
        if (junk) begin
            Dividend = 24'($urandom);
            Divisor  = 12'($urandom);
        end
        waited = 0;
        while (!Out_Valid && waited < 40) begin
            @(negedge Clk);
            waited++;
        end
        checkOutput("result_arrives", 32'(Out_Valid), 32'd1);
        repeat (hold) @(negedge Clk);
        Out_Ready = 1'b1;
        @(negedge Clk);
        Out_Ready = 1'b0;
        In_Valid  = 1'b0;
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish, compared=%0d", compared);
        $fatal(1, "[TB] simulation stalled");
    end

    initial begin
        exp_t r;
        logic [23:0] rd;
        logic [11:0] rs;

        Rst_N     = 1'b0;
        In_Valid  = 1'b0;
        Out_Ready = 1'b0;
        Dividend  = '0;
        Divisor   = '0;

        // Hand-computed anchors for the reference model itself.
        r = model(24'd100, 12'd7);
        checkOutput("pin_100_7_q", 32'(r.quot), 32'h00000E);
        checkOutput("pin_100_7_r", 32'(r.rem), 32'h002);
        r = model(24'hFFFF9C, 12'd7);
        checkOutput("pin_m100_7_q", 32'(r.quot), 32'hFFFFF2);
        checkOutput("pin_m100_7_r", 32'(r.rem), 32'hFFE);
        r = model(24'd100, 12'hFF9);
        checkOutput("pin_100_m7_r", 32'(r.rem), 32'h002);
        r = model(24'h7FFFFF, 12'h7FF);
        checkOutput("pin_max_q", 32'(r.quot), 32'h001002);
        checkOutput("pin_max_r", 32'(r.rem), 32'h001);
        r = model(24'h123456, 12'h000);
        checkOutput("pin_div0_r", 32'(r.rem), 32'h456);
        checkOutput("pin_div0_lat", 32'(r.lat), 32'd2);
        r = model(24'h800000, 12'hFFF);
        checkOutput("pin_ovf_q", 32'(r.quot), 32'h800000);
        checkOutput("pin_ovf_flag", 32'(r.ov), 32'd1);

        #12;
        checkOutput("reset_in_ready", 32'(In_Ready), 32'd1);
        checkOutput("reset_out_valid", 32'(Out_Valid), 32'd0);
        checkOutput("reset_quotient", 32'(Quotient), 32'd0);
        checkOutput("reset_remainder", 32'(Remainder), 32'd0);
        checkOutput("reset_flags", 32'({Div_By_Zero, Overflow}), 32'd0);

        @(negedge Clk);
        started = 1'b1;
        Rst_N   = 1'b1;

        applyStimulus(24'd100, 12'd7, 0, 1'b0);
        applyStimulus(24'hFFFF9C, 12'd7, 1, 1'b0);
        applyStimulus(24'd100, 12'hFF9, 0, 1'b1);
        applyStimulus(24'h7FFFFF, 12'h7FF, 10, 1'b1);
        applyStimulus(24'h123456, 12'h000, 2, 1'b0);
        applyStimulus(24'h800000, 12'hFFF, 0, 1'b0);
        applyStimulus(24'h000000, 12'd5, 0, 1'b0);

        // Abort an operation part-way through the iterations.
        @(negedge Clk);
        Dividend = 24'h7FFFFF;
        Divisor  = 12'd3;
        In_Valid = 1'b1;
        @(negedge Clk);
        In_Valid = 1'b0;
        repeat (9) @(negedge Clk);
        #2 Rst_N = 1'b0;
        #1;
        checkOutput("abort_out_valid", 32'(Out_Valid), 32'd0);
        checkOutput("abort_in_ready", 32'(In_Ready), 32'd1);
        @(negedge Clk);
        @(negedge Clk);
        Rst_N = 1'b1;
        applyStimulus(24'd100, 12'd7, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0:       rd = 24'h800000;
                1:       rd = 24'h7FFFFF;
                default: rd = 24'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       rs = 12'h000;
                1:       rs = 12'hFFF;
                2:       rs = 12'h800;
                3:       rs = 12'h001;
                default: rs = 12'($urandom);
            endcase
            applyStimulus(rd, rs, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        @(negedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
